// File: rtl/idma_nd_req_arbiter.sv
// Round-robin arbiter sharing one ND midend between NumReq frontends, with an in-order
// tracker that routes midend responses back to their owners. Optional macro: IDMA_ND_ARB_PERF_EN.
module idma_nd_req_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         idma_nd_req_t  = logic,
  parameter type         idma_rsp_t     = logic
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  idma_nd_req_t [NumReq-1:0]   req_i,
  input  logic         [NumReq-1:0]   req_valid_i,
  output logic         [NumReq-1:0]   req_ready_o,
  output idma_rsp_t    [NumReq-1:0]   rsp_o,
  output logic         [NumReq-1:0]   rsp_valid_o,
  input  logic         [NumReq-1:0]   rsp_ready_i,
  output idma_nd_req_t                nd_req_o,
  output logic                        nd_req_valid_o,
  input  logic                        nd_req_ready_i,
  input  idma_rsp_t                   nd_rsp_i,
  input  logic                        nd_rsp_valid_i,
  output logic                        nd_rsp_ready_o,
  output logic                        busy_o
`ifdef IDMA_ND_ARB_PERF_EN
  ,
  output logic [NumReq-1:0][31:0]     perf_done_o
`endif
);

  localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef logic [IdW-1:0]  id_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                  state_q, state_d;
  id_t                     grant_q, grant_d;
  id_t                     rr_ptr_q, rr_ptr_d;
  id_t [MaxOutstanding-1:0] mem_q, mem_d;
  ptr_t                    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic sel_found, full, empty, push, pop, bypass, route_vld, wr_en, rd_en;
  id_t  sel_id, push_id, route_id;

  function automatic id_t rr_idx(input id_t base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    return id_t'(sum);
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MaxOutstanding - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!sel_found && req_valid_i[rr_idx(rr_ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_id    = rr_idx(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    nd_req_o       = req_i[0];
    nd_req_valid_o = 1'b0;
    req_ready_o    = '0;
    push           = 1'b0;
    push_id        = sel_id;
    unique case (state_q)
      StIdle: begin
        if (sel_found && !full) begin
          nd_req_o            = req_i[sel_id];
          nd_req_valid_o      = 1'b1;
          req_ready_o[sel_id] = nd_req_ready_i;
          if (nd_req_ready_i) begin
            push     = 1'b1;
            rr_ptr_d = rr_idx(sel_id, 1);
          end else begin
            grant_d = sel_id;
            state_d = StLocked;
          end
        end
      end
      StLocked: begin
        push_id              = grant_q;
        nd_req_o             = req_i[grant_q];
        nd_req_valid_o       = req_valid_i[grant_q];
        req_ready_o[grant_q] = nd_req_ready_i;
        if (req_valid_i[grant_q] && nd_req_ready_i) begin
          push     = 1'b1;
          rr_ptr_d = rr_idx(grant_q, 1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!rst_ni) begin
      nd_req_o       = req_i[0];
      nd_req_valid_o = 1'b0;
      req_ready_o    = '0;
      push           = 1'b0;
    end
  end

  // Empty tracker routes to the ID being accepted right now (zero-transfer error responses).
  always_comb begin
    route_vld      = 1'b0;
    route_id       = mem_q[rd_ptr_q];
    bypass         = 1'b0;
    rsp_valid_o    = '0;
    nd_rsp_ready_o = 1'b0;
    if (!empty) begin
      route_vld = 1'b1;
    end else if (push) begin
      route_vld = 1'b1;
      route_id  = push_id;
      bypass    = 1'b1;
    end
    if (route_vld && rst_ni) begin
      rsp_valid_o[route_id] = nd_rsp_valid_i;
      nd_rsp_ready_o        = rsp_ready_i[route_id];
    end
    pop   = nd_rsp_valid_i & nd_rsp_ready_o;
    wr_en = push & ~(bypass & pop);
    rd_en = pop & ~bypass;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (wr_en && !rd_en) cnt_d = cnt_q + CntW'(1);
    else if (rd_en && !wr_en) cnt_d = cnt_q - CntW'(1);
  end

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) rsp_o[i] = nd_rsp_i;
    busy_o = rst_ni & ((state_q == StLocked) | (cnt_q != '0));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef IDMA_ND_ARB_PERF_EN
  logic [NumReq-1:0][31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (pop) perf_d[route_id] = perf_q[route_id] + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_done_o = perf_q;
`endif

`ifndef SYNTHESIS
  // A locked requester must keep valid high and its payload unchanged until accepted.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StLocked) |-> (req_valid_i[grant_q] && $stable(nd_req_o)));

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (empty && !push) |-> !nd_rsp_valid_i);
`endif

endmodule

// File: tb/tb_idma_nd_req_arbiter.sv
// Self-checking bench for idma_nd_req_arbiter: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model.
module tb_idma_nd_req_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned MO = 3;

  typedef logic [7:0] req_t;
  typedef logic [7:0] rsp_t;

  logic               clk = 1'b0;
  logic               rst_ni;
  req_t [N-1:0]       req_i;
  logic [N-1:0]       req_valid_i;
  logic [N-1:0]       req_ready_o;
  rsp_t [N-1:0]       rsp_o;
  logic [N-1:0]       rsp_valid_o;
  logic [N-1:0]       rsp_ready_i;
  req_t               nd_req_o;
  logic               nd_req_valid_o;
  logic               nd_req_ready_i;
  rsp_t               nd_rsp_i;
  logic               nd_rsp_valid_i;
  logic               nd_rsp_ready_o;
  logic               busy_o;
`ifdef IDMA_ND_ARB_PERF_EN
  logic [N-1:0][31:0] perf_done_o;
`endif

  idma_nd_req_arbiter #(
    .NumReq        (N),
    .MaxOutstanding(MO),
    .idma_nd_req_t (req_t),
    .idma_rsp_t    (rsp_t)
  ) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .rsp_o         (rsp_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .nd_req_o      (nd_req_o),
    .nd_req_valid_o(nd_req_valid_o),
    .nd_req_ready_i(nd_req_ready_i),
    .nd_rsp_i      (nd_rsp_i),
    .nd_rsp_valid_i(nd_rsp_valid_i),
    .nd_rsp_ready_o(nd_rsp_ready_o),
    .busy_o        (busy_o)
`ifdef IDMA_ND_ARB_PERF_EN
    ,
    .perf_done_o   (perf_done_o)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus intent
  bit        m_rst;
  bit        m_vld [N];
  req_t      m_dat [N];
  bit        m_nd_ready;
  bit        m_rsp_vld;
  rsp_t      m_rsp_dat;
  bit [N-1:0] m_rsp_rdy;

  // Reference model state
  int        trk_q [$];
  bit        locked;
  int        grant;
  int        rr;
  bit [31:0] perf [N];

  req_t      acc_log [$];
  int        n_checks = 0;
  int        n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step();
    bit [N-1:0] e_rdy     = '0;
    bit [N-1:0] e_rsp_vld = '0;
    bit   e_nd_vld = 1'b0, e_nd_rsp_rdy = 1'b0, e_busy, accept = 1'b0, pop = 1'b0, has_t = 1'b0;
    int   sel = -1;
    int   t   = 0;
    req_t e_dat;
    @(negedge clk);
    if (m_rst) begin
      for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
      m_rsp_vld = 1'b0;
    end
    e_dat = m_dat[0];
    if (!m_rst) begin
      if (locked) sel = grant;
      else if (trk_q.size() < MO)
        for (int k = 0; k < N; k++) if (sel < 0 && m_vld[(rr + k) % N]) sel = (rr + k) % N;
      if (sel >= 0) begin
        e_nd_vld   = 1'b1;
        e_dat      = m_dat[sel];
        e_rdy[sel] = m_nd_ready;
        accept     = m_nd_ready;
      end
      if (trk_q.size() > 0) begin
        has_t = 1'b1;
        t     = trk_q[0];
      end else if (accept) begin
        has_t = 1'b1;
        t     = sel;
      end
      if (!has_t) m_rsp_vld = 1'b0;
      if (has_t) begin
        e_rsp_vld[t] = m_rsp_vld;
        e_nd_rsp_rdy = m_rsp_rdy[t];
        pop          = m_rsp_vld && m_rsp_rdy[t];
      end
    end
    e_busy = !m_rst && (locked || trk_q.size() != 0);

    rst_ni = !m_rst;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = m_vld[i];
      req_i[i]       = m_dat[i];
    end
    nd_req_ready_i = m_nd_ready;
    nd_rsp_valid_i = m_rsp_vld;
    nd_rsp_i       = m_rsp_dat;
    rsp_ready_i    = m_rsp_rdy;
    #1;
    check_eq("nd_req_valid", nd_req_valid_o, e_nd_vld);
    check_eq("req_ready", req_ready_o, e_rdy);
    if (e_nd_vld || m_rst) check_eq("nd_req_data", nd_req_o, e_dat);
    check_eq("rsp_valid", rsp_valid_o, e_rsp_vld);
    check_eq("nd_rsp_ready", nd_rsp_ready_o, e_nd_rsp_rdy);
    check_eq("busy", busy_o, e_busy);
    for (int i = 0; i < N; i++) check_eq("rsp_data", rsp_o[i], m_rsp_dat);
`ifdef IDMA_ND_ARB_PERF_EN
    for (int i = 0; i < N; i++) check_eq("perf_done", perf_done_o[i], perf[i]);
`endif
    if (nd_req_valid_o && nd_req_ready_i) acc_log.push_back(nd_req_o);

    @(posedge clk);
    if (m_rst) begin
      trk_q.delete();
      locked = 1'b0;
      grant  = 0;
      rr     = 0;
      for (int i = 0; i < N; i++) perf[i] = '0;
    end else begin
      if (accept) begin
        trk_q.push_back(sel);
        rr         = (sel + 1) % N;
        locked     = 1'b0;
        m_vld[sel] = 1'b0;
      end else if (sel >= 0) begin
        locked = 1'b1;
        grant  = sel;
      end
      if (pop) begin
        void'(trk_q.pop_front());
        perf[t]   = perf[t] + 32'd1;
        m_rsp_vld = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    m_rst      = 1'b1;
    m_nd_ready = 1'b0;
    m_rsp_rdy  = '0;
    step();
    m_rst = 1'b0;
    acc_log.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 1'b0;
      m_dat[i] = req_t'(8'hA0 + i);
    end
    m_rsp_vld = 1'b0;
    m_rsp_dat = 8'h5A;
    do_reset();
    do_reset();

    // Two requesters always valid, midend always ready: strict alternation.
    m_nd_ready = 1'b1;
    m_rsp_rdy  = '1;
    for (int c = 0; c < 4; c++) begin
      m_vld[0]  = 1'b1;
      m_vld[1]  = 1'b1;
      m_rsp_vld = 1'b1;
      m_rsp_dat = rsp_t'($urandom);
      step();
    end
    check_eq("alt_count", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) check_eq("alt_order", acc_log[i], (i % 2 == 0) ? 8'hA0 : 8'hA1);

    // Grant stays locked on requester 0 while the midend stalls.
    do_reset();
    m_rsp_vld = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) m_vld[0] = 1'b1;
      if (c == 2) m_vld[1] = 1'b1;
      m_nd_ready = (c >= 5);
      step();
    end
    check_eq("lock_count", acc_log.size(), 2);
    check_eq("lock_first", acc_log[0], 8'hA0);
    check_eq("lock_second", acc_log[1], 8'hA1);

    // Fill the tracker, observe the blocked request, then free one slot.
    do_reset();
    m_nd_ready = 1'b1;
    for (int i = 0; i < N; i++) m_vld[i] = 1'b1;
    repeat (3) step();
    m_vld[0] = 1'b1;
    step();
    m_rsp_vld = 1'b1;
    m_rsp_rdy = '1;
    step();
    step();
    check_eq("full_accepts", acc_log.size(), 4);

    // Responses follow acceptance order; a stalled owner holds the tracker head.
    do_reset();
    m_nd_ready = 1'b1;
    m_vld[1]   = 1'b1;
    step();
    m_vld[0] = 1'b1;
    step();
    m_nd_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      m_rsp_vld = 1'b1;
      m_rsp_rdy = (c < 3) ? 3'b101 : 3'b111;
      m_rsp_dat = rsp_t'(8'hC0 + c);
      step();
    end

    // Bypass: response in the acceptance cycle with an empty tracker.
    do_reset();
    m_vld[1]   = 1'b1;
    m_nd_ready = 1'b1;
    m_rsp_vld  = 1'b1;
    m_rsp_rdy  = '1;
    step();
    m_nd_ready = 1'b0;
    step();

    // Reset while locked with two outstanding.
    do_reset();
    m_nd_ready = 1'b1;
    m_vld[0]   = 1'b1;
    m_vld[1]   = 1'b1;
    repeat (2) step();
    m_nd_ready = 1'b0;
    m_vld[2]   = 1'b1;
    repeat (2) step();
    do_reset();
    step();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!m_vld[i] && $urandom_range(1) == 0) begin
            m_vld[i] = 1'b1;
            m_dat[i] = req_t'($urandom);
          end
        end
        m_nd_ready = ($urandom_range(2) != 0);
        m_rsp_vld  = ($urandom_range(1) == 0);
        m_rsp_dat  = rsp_t'($urandom);
        m_rsp_rdy  = N'($urandom);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
